ifetch_unit: RTL and testbench

Instruction fetch and sequencing unit for the single-cycle MIPS-subset CPU. It is the producer side of the control decoder's interface.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Splits each word into Op/Fun/register/immediate fields and presents them to the control decoder and datapath.
- Consumes the decoder's nPC_sel and the ALU's equal flag to compute the next PC.
- Includes a wait-cycle counter that flags a hung memory and re-issues the fetch.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/ifetch_unit_if.sv | 27 ++
 rtl/npc_calc.sv | 33 +++
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset CPU: opcode/funct constants,
// instruction word layout and fetch-sequencer state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_e;

    // R-type view of an instruction word; I/J fields are slices of it
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] fun;
    } instr_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory request/acknowledge bus.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : byte address of the requested word (master -> slave)
//   imem_ack   : read data valid this cycle (slave -> master)
//   imem_rdata : instruction word (slave -> master)
interface ifetch_unit_if;

    logic                         imem_req;
    logic [cpu_pkg::INSTR_W-1:0]  imem_addr;
    logic                         imem_ack;
    logic [cpu_pkg::INSTR_W-1:0]  imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/npc_calc.sv
// Next-PC computation shared by the fetch unit and the pipelined core.
//   pc          : current PC
//   imm16       : branch offset in words (sign-extended)
//   jump_target : 26-bit J-type target field
//   taken       : branch condition satisfied
//   is_jump     : J-type instruction, overrides the branch path
//   next_pc     : resulting PC (modulo 2^32)
module npc_calc (
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] jump_target,
    input  logic        taken,
    input  logic        is_jump,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    // Jump has priority over branch; adds wrap naturally at 32 bits
    always_comb begin
        next_pc = pc_plus4;
        if (is_jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch and sequencing unit.
// Fetches a word over the imem bus, holds it in ir while the datapath works
// on it, then steps pc (sequential, BEQ-style branch, or optional jump).
// A wait counter abandons a request that is not acknowledged in MAX_WAIT
// cycles, pulses fetch_err and re-requests the same address.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   imem              : instruction memory bus (master side)
//   instr_valid       : decoded fields valid
//   instr_ready       : datapath retires the current instruction
//   Op/Fun/rs/rt/rd/imm16 : instruction fields, combinational from ir
//   nPC_sel, equal    : branch select and ALU equal flag, sampled at retire
//   pc                : registered PC
//   fetch_err         : one-cycle pulse on fetch timeout
// Build option: define IFETCH_JUMP_EN to redirect pc on J-type opcodes.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    ifetch_unit_if.master       imem,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [5:0]          Op,
    output logic [5:0]          Fun,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [15:0]         imm16,
    input  logic                nPC_sel,
    input  logic                equal,
    output logic [31:0]         pc,
    output logic                fetch_err
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    fetch_state_e       state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0]        pc_nxt;
    instr_t             ir, ir_nxt;
    logic               req_c, valid_c, err_c;
    logic               is_jump;
    logic [31:0]        next_pc;

    // Field decode straight from the instruction register
    assign Op    = ir.op;
    assign rs    = ir.rs;
    assign rt    = ir.rt;
    assign rd    = ir.rd;
    assign Fun   = ir.fun;
    assign imm16 = {ir.rd, ir.shamt, ir.fun};

`ifdef IFETCH_JUMP_EN
    assign is_jump = (ir.op == OP_J);
`else
    assign is_jump = 1'b0;
`endif

    npc_calc u_npc_calc (
        .pc          (pc),
        .imm16       (imm16),
        .jump_target (ir[25:0]),
        .taken       (nPC_sel & equal),
        .is_jump     (is_jump),
        .next_pc     (next_pc)
    );

    // State, counter, pc and ir registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            pc       <= {RESET_PC[31:2], 2'b00};
            ir       <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_nxt       = pc;
        ir_nxt       = ir;
        req_c        = 1'b0;
        valid_c      = 1'b0;
        err_c        = 1'b0;
        case (state)
            S_FETCH: begin
                req_c     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_ack) begin
                    req_c        = 1'b1;
                    ir_nxt       = imem.imem_rdata;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_ISSUE;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Request withdrawn for this one cycle, re-raised by S_FETCH
                    err_c        = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_FETCH;
                end else begin
                    req_c        = 1'b1;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_ISSUE: begin
                valid_c = 1'b1;
                if (instr_ready) begin
                    pc_nxt    = next_pc;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is held
    assign imem.imem_req  = req_c & ~reset;
    assign imem.imem_addr = pc;
    assign instr_valid    = valid_c & ~reset;
    assign fetch_err      = err_c & ~reset;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned MAXW   = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid, instr_ready;
    logic [5:0]  Op, Fun;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        nPC_sel, equal;
    logic [31:0] pc;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_pc;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Op          (Op),
        .Fun         (Fun),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .nPC_sel     (nPC_sel),
        .equal       (equal),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference next-PC: sequential, signed word-offset branch, optional jump
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic sel, input logic eq);
        logic [31:0] seq;
        int          delta;
        seq   = cur + 32'd4;
        delta = int'($signed(word[15:0]));
`ifdef IFETCH_JUMP_EN
        if (word[31:26] == OP_J) return (seq & 32'hF000_0000) | (32'(word[25:0]) << 2);
`endif
        if (sel && eq) return seq + 32'(delta * 4);
        return seq;
    endfunction

    function automatic logic [42:0] fields_of(input logic [31:0] w);
        return {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]};
    endfunction

    // Holds reset for two edges, releases just after a rising edge, ends at the
    // falling edge of the first fetch cycle
    task automatic apply_reset();
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        instr_ready = 1'b0;
        nPC_sel = 1'b0;
        equal = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        exp_pc = RST_PC;
    endtask

    // Runs one fetch/issue/retire transaction and reports what it observed
    task automatic do_instr(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                            input logic sel, input logic eq,
                            output logic got, output logic [31:0] addr_seen, output int lat,
                            output logic [42:0] snap, output logic stable, output logic [31:0] pc_after);
        logic [31:0] p0;
        got = 1'b0; addr_seen = '0; lat = 0; snap = '0; stable = 1'b1; pc_after = '0;
        for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) @(negedge clk);
        if (bus.imem_req !== 1'b1) return;
        addr_seen = bus.imem_addr;
        bus.imem_ack = 1'($urandom_range(0, 1));
        bus.imem_rdata = ~word;
        for (int k = 0; k <= ack_dly; k++) begin
            @(negedge clk);
            lat++;
            bus.imem_ack = (k == ack_dly);
            bus.imem_rdata = (k == ack_dly) ? word : $urandom;
        end
        for (int i = 0; i < 5 && instr_valid !== 1'b1; i++) begin
            @(negedge clk);
            lat++;
            bus.imem_ack = 1'b0;
        end
        if (instr_valid !== 1'b1) return;
        got = 1'b1;
        snap = {Op, rs, rt, rd, Fun, imm16};
        p0 = pc;
        for (int i = 0; i < rdy_dly; i++) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            nPC_sel = 1'($urandom_range(0, 1));
            equal = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ({Op, rs, rt, rd, Fun, imm16} !== snap || pc !== p0 || instr_valid !== 1'b1) stable = 1'b0;
        end
        bus.imem_ack = 1'b0;
        instr_ready = 1'b1;
        nPC_sel = sel;
        equal = eq;
        @(negedge clk);
        instr_ready = 1'b0;
        nPC_sel = 1'($urandom_range(0, 1));
        equal = 1'($urandom_range(0, 1));
        pc_after = pc;
    endtask

    task automatic test_reset();
        logic got, stb; logic [31:0] a, pa; int lat; logic [42:0] s;
        reset = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        instr_ready = 1'b0; nPC_sel = 1'b0; equal = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h want 00003000", pc); end
        n_checks++; if ({Op, rs, rt, rd, Fun, imm16} !== 43'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {Op, rs, rt, rd, Fun, imm16}); end
        bus.imem_ack = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        exp_pc = RST_PC;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL first_req: req %b addr %h want 1 00003000", bus.imem_req, bus.imem_addr); end
        do_instr(32'h0022_1820, 0, 0, 1'b0, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL first_instr_timeout: got %b want 1", got); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL first_latency: got %0d want 2", lat); end
        n_checks++; if (Op !== 6'd0 || Fun !== FN_ADD || rd !== 5'd3 || rs !== 5'd1 || rt !== 5'd2) begin
            n_fail++; $display("FAIL add_fields: Op %h Fun %h rs %0d rt %0d rd %0d want 0 20 1 2 3", s[42:37], s[21:16], s[36:32], s[31:27], s[26:22]); end
        n_checks++; if (pa !== 32'h0000_3004) begin n_fail++; $display("FAIL add_next_pc: got %h want 00003004", pa); end
    endtask

    task automatic test_branch();
        logic got, stb; logic [31:0] a, pa; int lat; logic [42:0] s;
        apply_reset();
        do_instr(32'h1000_0003, 0, 0, 1'b1, 1'b1, got, a, lat, s, stb, pa);
        n_checks++; if (pa !== 32'h0000_3010) begin n_fail++; $display("FAIL beq_taken: got %h want 00003010", pa); end
        n_checks++; if (bus.imem_addr !== 32'h0000_3010 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL beq_taken_addr: got %h req %b want 00003010", bus.imem_addr, bus.imem_req); end
        apply_reset();
        do_instr(32'h1000_0003, 0, 0, 1'b1, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (pa !== 32'h0000_3004) begin n_fail++; $display("FAIL beq_not_taken: got %h want 00003004", pa); end
    endtask

    task automatic test_negative_branch();
        logic got, stb; logic [31:0] a, pa; int lat; logic [42:0] s;
        apply_reset();
        do_instr(32'h1000_0001, 0, 0, 1'b1, 1'b1, got, a, lat, s, stb, pa);
        n_checks++; if (pa !== 32'h0000_3008) begin n_fail++; $display("FAIL fwd_branch: got %h want 00003008", pa); end
        do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, got, a, lat, s, stb, pa);
        n_checks++; if (a !== 32'h0000_3008 || pa !== 32'h0000_3004) begin n_fail++; $display("FAIL neg_branch: from %h to %h want 00003008 to 00003004", a, pa); end
        do_instr(32'h1000_F3FD, 0, 0, 1'b1, 1'b1, got, a, lat, s, stb, pa);
        n_checks++; if (pa !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL neg_wrap_branch: got %h want fffffffc", pa); end
        do_instr(32'h1000_0005, 0, 0, 1'b1, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (a !== 32'hFFFF_FFFC || pa !== 32'h0000_0000) begin n_fail++; $display("FAIL pc_wrap: from %h to %h want fffffffc to 00000000", a, pa); end
    endtask

    task automatic test_timeout();
        logic got, stb; logic [31:0] a, pa; int lat; logic [42:0] s;
        int err_cnt, err_at, low_cnt, low_at;
        apply_reset();
        err_cnt = 0; err_at = -1; low_cnt = 0; low_at = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (fetch_err === 1'b1) begin err_cnt++; err_at = i; end
            if (bus.imem_req !== 1'b1) begin low_cnt++; low_at = i; end
        end
        n_checks++; if (err_cnt != 1 || err_at != 15) begin n_fail++; $display("FAIL timeout_err: %0d pulses at cycle %0d want 1 at 15", err_cnt, err_at); end
        n_checks++; if (low_cnt != 1 || low_at != 15) begin n_fail++; $display("FAIL timeout_req_drop: %0d low cycles at %0d want 1 at 15", low_cnt, low_at); end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL retry_req: req %b addr %h want 1 00003000", bus.imem_req, bus.imem_addr); end
        do_instr(32'h0022_1820, 2, 0, 1'b0, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (got !== 1'b1 || lat != 4) begin n_fail++; $display("FAIL retry_ack3: got %b latency %0d want 1 4", got, lat); end
        n_checks++; if (pa !== 32'h0000_3004) begin n_fail++; $display("FAIL retry_next_pc: got %h want 00003004", pa); end
    endtask

    task automatic test_stall_and_mid_reset();
        logic got, stb; logic [31:0] a, pa; int lat; logic [42:0] s;
        apply_reset();
        do_instr(32'h1234_5678, 0, 10, 1'b0, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (stb !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b want 1", stb); end
        n_checks++; if (s !== fields_of(32'h1234_5678)) begin n_fail++; $display("FAIL stall_fields: got %h want %h", s, fields_of(32'h1234_5678)); end
        n_checks++; if (pa !== 32'h0000_3004) begin n_fail++; $display("FAIL stall_next_pc: got %h want 00003004", pa); end
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: got %b want 1", bus.imem_req); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0 || pc !== RST_PC) begin n_fail++; $display("FAIL mid_reset: req %b pc %h want 0 00003000", bus.imem_req, pc); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        exp_pc = RST_PC;
        do_instr(32'h0000_0000, 1, 0, 1'b0, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (got !== 1'b1 || a !== 32'h0000_3000 || pa !== 32'h0000_3004) begin n_fail++; $display("FAIL post_reset: got %b addr %h next %h want 1 00003000 00003004", got, a, pa); end
    endtask

    task automatic test_jump();
        logic got, stb; logic [31:0] a, pa; int lat; logic [42:0] s;
        logic [31:0] want;
`ifdef IFETCH_JUMP_EN
        want = 32'h0000_3040;
`else
        want = 32'h0000_3004;
`endif
        apply_reset();
        do_instr(32'h0800_0C10, 0, 0, 1'b0, 1'b0, got, a, lat, s, stb, pa);
        n_checks++; if (pa !== want) begin n_fail++; $display("FAIL jump_next_pc: got %h want %h", pa, want); end
    endtask

    task automatic test_random();
        logic got, stb; logic [31:0] a, pa, w; int lat; logic [42:0] s;
        int ad, rdl; logic sel, eq;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       w = {OP_RTYPE, 20'($urandom), FN_ADD};
                1:       w = {OP_BEQ, 26'($urandom)};
                2:       w = {OP_J, 26'($urandom)};
                default: w = $urandom;
            endcase
            ad  = $urandom_range(0, 4);
            rdl = $urandom_range(0, 3);
            sel = 1'($urandom_range(0, 1));
            eq  = 1'($urandom_range(0, 1));
            do_instr(w, ad, rdl, sel, eq, got, a, lat, s, stb, pa);
            n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rnd_handshake[%0d]: got %b want 1", n, got); end
            n_checks++; if (a !== exp_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, a, exp_pc); end
            n_checks++; if (lat != ad + 2) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, ad + 2); end
            n_checks++; if (s !== fields_of(w) || stb !== 1'b1) begin n_fail++; $display("FAIL rnd_fields[%0d]: got %h stable %b want %h 1", n, s, stb, fields_of(w)); end
            exp_pc = model_next(exp_pc, w, sel, eq);
            n_checks++; if (pa !== exp_pc) begin n_fail++; $display("FAIL rnd_next_pc[%0d]: got %h want %h (word %h sel %b eq %b)", n, pa, exp_pc, w, sel, eq); end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_negative_branch();
        test_timeout();
        test_stall_and_mid_reset();
        test_jump();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
